// File: rtl/muxed_input_scheduler.sv
// Time-shares NUM_CH slow status channels over one value/ID field, one slot per
// interface sync rising edge, with optional change-priority scheduling and an interface-loss watchdog.
module muxed_input_scheduler #(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned ID_WIDTH = 8,
  parameter int unsigned MODE     = 0,
  parameter int unsigned TIMEOUT  = 2700000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sync,
  input  logic                      enable,
  input  logic [NUM_CH*WIDTH-1:0]   in_values,
  output logic [WIDTH-1:0]          out_value,
  output logic [ID_WIDTH-1:0]       out_id,
  output logic                      out_valid,
  output logic [NUM_CH-1:0]         dirty_mask,
  output logic                      timeout
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [1:0]          rst_sync_q;
  logic                rst_int_n;
  logic [2:0]          s_q;
  logic                sync_edge;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                timeout_q;
  logic [ID_WIDTH-1:0] ptr_q;
  logic [ID_WIDTH-1:0] out_id_q;
  logic [WIDTH-1:0]    out_value_q;
  logic                out_valid_q;
  logic [NUM_CH-1:0]   dirty_q;
  logic [WIDTH-1:0]    last_sent_q [NUM_CH];

  logic [WIDTH-1:0]    ch_val [NUM_CH];
  logic [NUM_CH-1:0]   dirty;
  logic [2*NUM_CH-1:0] dirty_rot;
  logic                found;
  logic [WIDTH-1:0]    sel_val;
  int unsigned         ptr_int, nxt_int, sel_int;

  // Reset asserts asynchronously, releases on the second clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  assign sync_edge = (s_q[2:1] == 2'b01);

  always_comb begin
    cnt_d = cnt_q;
    if (sync_edge)                    cnt_d = '0;
    else if (cnt_q < CW'(TIMEOUT))    cnt_d = cnt_q + CW'(1);
  end

  // Doubling the dirty vector and shifting by the scan start turns the
  // circular search into a plain lowest-set-bit search.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_val[i] = in_values[i*WIDTH +: WIDTH];
      dirty[i]  = (ch_val[i] != last_sent_q[i]);
    end
    ptr_int   = 32'(ptr_q);
    nxt_int   = (ptr_int >= NUM_CH - 1) ? 0 : ptr_int + 1;
    sel_int   = nxt_int;
    found     = 1'b0;
    dirty_rot = {dirty, dirty} >> nxt_int;
    if (MODE == 1) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (!found && dirty_rot[k]) begin
          found   = 1'b1;
          sel_int = nxt_int + k;
          if (sel_int >= NUM_CH) sel_int = sel_int - NUM_CH;
        end
      end
    end
    sel_val = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (i == sel_int) sel_val = ch_val[i];
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      s_q         <= '0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
      ptr_q       <= ID_WIDTH'(NUM_CH - 1);
      out_id_q    <= '0;
      out_value_q <= '0;
      out_valid_q <= 1'b0;
      dirty_q     <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) last_sent_q[i] <= '0;
    end else begin
      s_q         <= {s_q[1:0], sync};
      cnt_q       <= cnt_d;
      timeout_q   <= (cnt_d == CW'(TIMEOUT));
      dirty_q     <= dirty;
      out_valid_q <= 1'b0;
      if (sync_edge && enable) begin
        out_valid_q <= 1'b1;
        out_id_q    <= ID_WIDTH'(sel_int);
        out_value_q <= sel_val;
        ptr_q       <= ID_WIDTH'(sel_int);
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (i == sel_int) last_sent_q[i] <= ch_val[i];
        end
      end
    end
  end

  assign out_value  = out_value_q;
  assign out_id     = out_id_q;
  assign out_valid  = out_valid_q;
  assign dirty_mask = dirty_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_muxed_input_scheduler.sv
// Bench for muxed_input_scheduler: a round-robin and a change-priority instance
// share stimulus; a scoreboard of expected (id,value) pairs is checked against each.
module tb_muxed_input_scheduler;

  localparam int NC = 4;
  localparam int W  = 16;
  localparam int TO = 100;

  logic             clk = 1'b0;
  logic             rst_n, sync, enable;
  logic [NC*W-1:0]  in_values;
  logic [W-1:0]     v0, v1;
  logic [7:0]       id0, id1;
  logic             val0, val1, to0, to1;
  logic [NC-1:0]    dm0, dm1;

  always #5 clk = ~clk;

  muxed_input_scheduler #(.NUM_CH(NC), .WIDTH(W), .ID_WIDTH(8), .MODE(0), .TIMEOUT(TO)) dut0 (
    .clk(clk), .rst_n(rst_n), .sync(sync), .enable(enable), .in_values(in_values),
    .out_value(v0), .out_id(id0), .out_valid(val0), .dirty_mask(dm0), .timeout(to0));

  muxed_input_scheduler #(.NUM_CH(NC), .WIDTH(W), .ID_WIDTH(8), .MODE(1), .TIMEOUT(TO)) dut1 (
    .clk(clk), .rst_n(rst_n), .sync(sync), .enable(enable), .in_values(in_values),
    .out_value(v1), .out_id(id1), .out_valid(val1), .dirty_mask(dm1), .timeout(to1));

  typedef struct packed {
    logic [7:0]   id;
    logic [W-1:0] val;
  } exp_t;

  exp_t       sb0[$];
  exp_t       sb1[$];
  int         checks = 0;
  int         errors = 0;
  int         pulse_cyc = 0;
  logic [W-1:0] cur [NC];
  logic [W-1:0] m_last [2][NC];
  int           m_ptr [2];
  logic [7:0]   m_id [2];
  logic [W-1:0] m_val [2];

  task automatic apply_inputs();
    for (int i = 0; i < NC; i++) in_values[i*W +: W] = cur[i];
  endtask

  function automatic logic [NC-1:0] model_dirty(input int m);
    logic [NC-1:0] r;
    for (int i = 0; i < NC; i++) r[i] = (cur[i] != m_last[m][i]);
    return r;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_ptr[m] = NC - 1;
      m_id[m]  = '0;
      m_val[m] = '0;
      for (int i = 0; i < NC; i++) m_last[m][i] = '0;
    end
    sb0.delete();
    sb1.delete();
  endtask

  task automatic model_pick(input int m);
    int sel;
    int idx;
    exp_t e;
    sel = (m_ptr[m] + 1) % NC;
    if (m == 1) begin
      for (int k = 1; k <= NC; k++) begin
        idx = (m_ptr[m] + k) % NC;
        if (cur[idx] != m_last[m][idx]) begin
          sel = idx;
          break;
        end
      end
    end
    m_ptr[m]       = sel;
    m_last[m][sel] = cur[sel];
    m_id[m]        = 8'(sel);
    m_val[m]       = cur[sel];
    e.id  = m_id[m];
    e.val = m_val[m];
    if (m == 0) sb0.push_back(e);
    else        sb1.push_back(e);
  endtask

  // Advance one clock, sampling at the falling edge and draining the scoreboards.
  task automatic step();
    exp_t e;
    @(negedge clk);
    pulse_cyc++;
    if (rst_n) begin
      if (val0) begin
        checks++;
        if (sb0.size() == 0) begin
          errors++;
          $display("FAIL rr_unexpected_valid: got id=%0h value=%0h, required no valid", id0, v0);
        end else begin
          e = sb0.pop_front();
          if ({id0, v0} !== {e.id, e.val}) begin
            errors++;
            $display("FAIL rr_output: got id=%0h value=%0h, required id=%0h value=%0h", id0, v0, e.id, e.val);
          end
        end
        checks++;
        if (pulse_cyc < 2 || pulse_cyc > 4) begin
          errors++;
          $display("FAIL rr_latency: got %0d clocks, required 2..4", pulse_cyc);
        end
      end
      if (val1) begin
        checks++;
        if (sb1.size() == 0) begin
          errors++;
          $display("FAIL cp_unexpected_valid: got id=%0h value=%0h, required no valid", id1, v1);
        end else begin
          e = sb1.pop_front();
          if ({id1, v1} !== {e.id, e.val}) begin
            errors++;
            $display("FAIL cp_output: got id=%0h value=%0h, required id=%0h value=%0h", id1, v1, e.id, e.val);
          end
        end
        checks++;
        if (pulse_cyc < 2 || pulse_cyc > 4) begin
          errors++;
          $display("FAIL cp_latency: got %0d clocks, required 2..4", pulse_cyc);
        end
      end
    end
  endtask

  task automatic pulse();
    sync = 1'b1;
    pulse_cyc = 0;
    if (enable) begin
      model_pick(0);
      model_pick(1);
    end
    repeat (4) step();
    sync = 1'b0;
    repeat (4) step();
    checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      errors++;
      $display("FAIL missing_valid: got %0d/%0d pending, required 0/0", sb0.size(), sb1.size());
      sb0.delete();
      sb1.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sync = 1'b0; enable = 1'b1;
    cur[0] = 16'h1111; cur[1] = 16'h2222; cur[2] = 16'h3333; cur[3] = 16'h4444;
    apply_inputs();
    model_reset();
    repeat (3) step();
    checks++;
    if ({v0, id0, val0, dm0, to0} !== '0) begin
      errors++;
      $display("FAIL rr_reset_outputs: got value=%0h id=%0h valid=%b dirty=%b timeout=%b, required all 0", v0, id0, val0, dm0, to0);
    end
    checks++;
    if ({v1, id1, val1, dm1, to1} !== '0) begin
      errors++;
      $display("FAIL cp_reset_outputs: got value=%0h id=%0h valid=%b dirty=%b timeout=%b, required all 0", v1, id1, val1, dm1, to1);
    end
    rst_n = 1'b1;
    repeat (4) step();
    checks++;
    if (dm0 !== model_dirty(0) || dm1 !== model_dirty(1)) begin
      errors++;
      $display("FAIL post_reset_dirty: got %b/%b, required %b/%b", dm0, dm1, model_dirty(0), model_dirty(1));
    end
  endtask

  task automatic test_round_robin();
    for (int p = 0; p < 6; p++) begin
      pulse();
      checks++;
      if (dm0 !== model_dirty(0) || dm1 !== model_dirty(1)) begin
        errors++;
        $display("FAIL dirty_decay p%0d: got %b/%b, required %b/%b", p, dm0, dm1, model_dirty(0), model_dirty(1));
      end
    end
  endtask

  task automatic test_change_priority();
    repeat (3) pulse();
    cur[2] = 16'hABCD;
    apply_inputs();
    step();
    step();
    checks++;
    if (dm1 !== model_dirty(1)) begin
      errors++;
      $display("FAIL cp_single_dirty: got %b, required %b", dm1, model_dirty(1));
    end
    pulse();
    cur[1] = 16'h5555;
    cur[3] = 16'h7777;
    apply_inputs();
    pulse();
    pulse();
    checks++;
    if (dm1 !== model_dirty(1)) begin
      errors++;
      $display("FAIL cp_dirty_cleared: got %b, required %b", dm1, model_dirty(1));
    end
  endtask

  task automatic test_enable();
    enable = 1'b0;
    for (int p = 0; p < 3; p++) begin
      cur[p] = cur[p] + 16'h0101;
      apply_inputs();
      pulse();
      checks++;
      if ({id0, v0, id1, v1} !== {m_id[0], m_val[0], m_id[1], m_val[1]}) begin
        errors++;
        $display("FAIL disabled_hold: got %0h/%0h %0h/%0h, required %0h/%0h %0h/%0h",
                 id0, v0, id1, v1, m_id[0], m_val[0], m_id[1], m_val[1]);
      end
      checks++;
      if (to0 !== 1'b0 || to1 !== 1'b0) begin
        errors++;
        $display("FAIL disabled_timeout: got %b/%b, required 0/0", to0, to1);
      end
    end
    enable = 1'b1;
    pulse();
  endtask

  task automatic test_watchdog();
    sync = 1'b1;
    pulse_cyc = 0;
    model_pick(0);
    model_pick(1);
    repeat (4) step();
    sync = 1'b0;
    while (pulse_cyc < TO + 2) step();
    checks++;
    if (to0 !== 1'b0 || to1 !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got %b/%b, required 0/0", to0, to1);
    end
    step();
    checks++;
    if (to0 !== 1'b1 || to1 !== 1'b1) begin
      errors++;
      $display("FAIL timeout_rise: got %b/%b, required 1/1", to0, to1);
    end
    repeat (10 * TO) step();
    checks++;
    if (to0 !== 1'b1 || to1 !== 1'b1) begin
      errors++;
      $display("FAIL timeout_no_wrap: got %b/%b, required 1/1", to0, to1);
    end
    sync = 1'b1;
    pulse_cyc = 0;
    model_pick(0);
    model_pick(1);
    step();
    step();
    checks++;
    if (to0 !== 1'b1) begin
      errors++;
      $display("FAIL timeout_hold_edge: got %b, required 1", to0);
    end
    step();
    checks++;
    if (to0 !== 1'b0 || to1 !== 1'b0) begin
      errors++;
      $display("FAIL timeout_drop: got %b/%b, required 0/0", to0, to1);
    end
    step();
    sync = 1'b0;
    // Next edge lands in the cycle the counter would have reached TIMEOUT.
    while (pulse_cyc < TO) step();
    sync = 1'b1;
    pulse_cyc = 0;
    model_pick(0);
    model_pick(1);
    for (int c = 0; c < 8; c++) begin
      step();
      if (c == 3) sync = 1'b0;
      checks++;
      if (to0 !== 1'b0 || to1 !== 1'b0) begin
        errors++;
        $display("FAIL timeout_edge_race c%0d: got %b/%b, required 0/0", c, to0, to1);
      end
    end
    checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      errors++;
      $display("FAIL watchdog_missing_valid: got %0d/%0d pending, required 0/0", sb0.size(), sb1.size());
      sb0.delete();
      sb1.delete();
    end
  endtask

  task automatic test_reset_mid();
    for (int p = 0; p < NC && m_ptr[0] != 2; p++) pulse();
    checks++;
    if (id0 !== 8'd2) begin
      errors++;
      $display("FAIL rr_pointer_setup: got id=%0h, required 2", id0);
    end
    repeat (TO + 10) step();
    checks++;
    if (to0 !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_timeout: got %b, required 1", to0);
    end
    sync = 1'b1;
    step();
    step();
    @(posedge clk);
    #2 rst_n = 1'b0;
    sync = 1'b0;
    #1;
    checks++;
    if ({v0, id0, val0, dm0, to0, v1, id1, val1, dm1, to1} !== '0) begin
      errors++;
      $display("FAIL async_reset: got %0h %0h %b %b %b / %0h %0h %b %b %b, required all 0",
               v0, id0, val0, dm0, to0, v1, id1, val1, dm1, to1);
    end
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();
    pulse();
    checks++;
    if (id0 !== 8'd0 || id1 !== 8'd0) begin
      errors++;
      $display("FAIL first_after_reset: got %0h/%0h, required 0/0", id0, id1);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_change_priority();
    test_enable();
    test_watchdog();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: got no completion, required finish before 500000");
    $fatal(1, "time limit");
  end

endmodule
